// File: rtl/mac_rx_deserializer.sv
// Serial MAC link receiver: recovers start/data/stop framed bytes from the idle-high
// line and presents them through a one-entry valid/ready holding register.
module mac_rx_deserializer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mac_rx,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              rx_busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W) + 1;

  localparam logic [CYC_W-1:0] HALF_CYC = CYC_W'(HALF - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              sync1;
  logic              rxs;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= mac_rx;
      rxs   <= sync1;
    end
  end

  // Frame FSM with registered delivery, flag pulses and busy indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            cyc     <= '0;
            bit_cnt <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cyc == HALF_CYC) begin
            cyc     <= '0;
            bit_cnt <= '0;
            if (!rxs) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        DATA: begin
          if (cyc == LAST_CYC) begin
            cyc   <= '0;
            shreg <= DATA_W'({rxs, shreg} >> 1);
            if (bit_cnt == LAST_BIT) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        STOP: begin
          if (cyc == LAST_CYC) begin
            cyc     <= '0;
            bit_cnt <= '0;
            if (rxs) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              // Load when empty or being popped this cycle; otherwise drop the byte.
              if (!rx_valid || rx_ready) begin
                data_out <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (rxs) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_cnt <= '0;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cyc     <= '0;
          bit_cnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
